// File: rtl/alu_pwm_out.sv
// 16-step PWM driven by a latched ALU result; the shadow duty is applied to
// the active duty only at period boundaries so the output never glitches.
module alu_pwm_out #(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] duty_in,
    input  logic       carry_in,
    input  logic       neg_in,
    input  logic       cero_in,
    output logic       pwm_out,
    output logic       period_start,
    output logic [4:0] duty_active,
    output logic       pending
);
    // state | meaning
    // IDLE  | counters held at 0, output low, waiting for en
    // RUN   | prescaler and step counter advancing, PWM active
    typedef enum logic {IDLE, RUN} state_t;

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    step_q, step_d;
    logic [4:0]    shadow_q, shadow_d;
    logic [4:0]    active_q, active_d;
    logic          pwm_q, pwm_d;
    logic          ps_q, ps_d;
    logic          tick;
    logic [4:0]    eff_duty;

    // carry saturates to full-on; negative or zero results mean off
    always_comb begin
        if (carry_in)                eff_duty = 5'd16;
        else if (neg_in || cero_in)  eff_duty = 5'd0;
        else                         eff_duty = {1'b0, duty_in};
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        step_d   = step_q;
        active_d = active_q;
        shadow_d = load ? eff_duty : shadow_q;
        ps_d     = 1'b0;
        tick     = 1'b0;
        pwm_d    = (state_q == RUN) && ({1'b0, step_q} < active_q);
        case (state_q)
            IDLE: begin
                pre_d  = '0;
                step_d = '0;
                if (en) begin
                    state_d  = RUN;
                    active_d = shadow_q;
                    ps_d     = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    step_d  = '0;
                end else begin
                    tick  = (pre_q == PRE_MAX);
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        step_d = step_q + 4'd1;
                        // old shadow goes live here even if a load lands this cycle
                        if (step_q == 4'd15) begin
                            active_d = shadow_q;
                            ps_d     = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            step_q   <= '0;
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign duty_active  = active_q;
    assign pending      = (shadow_q != active_q);
endmodule

// File: tb/tb_alu_pwm_out.sv
// Bench for alu_pwm_out at CLK_DIV=2: a period-position model checked every
// cycle, plus directed scenarios with hand-computed high-time counts.
module tb_alu_pwm_out;
    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] duty_in = 4'd0;
    logic       carry_in = 1'b0;
    logic       neg_in = 1'b0;
    logic       cero_in = 1'b0;
    logic       pwm_out;
    logic       period_start;
    logic [4:0] duty_active;
    logic       pending;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    alu_pwm_out #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .duty_in(duty_in),
        .carry_in(carry_in), .neg_in(neg_in), .cero_in(cero_in),
        .pwm_out(pwm_out), .period_start(period_start),
        .duty_active(duty_active), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: position within the period in clock cycles, not prescaler/step.
    bit m_run = 0;
    int m_pos = 0;
    int m_shadow = 0;
    int m_active = 0;
    bit m_pwm = 0;
    bit m_ps = 0;

    function automatic int eff(input int d, input bit c, input bit n, input bit z);
        if (c) return 16;
        if (n || z) return 0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_pos = 0; m_shadow = 0; m_active = 0; m_pwm = 0; m_ps = 0;
        end else begin
            m_pwm = m_run && ((m_pos / CLK_DIV) < m_active);
            m_ps  = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_pos = 0; m_active = m_shadow; m_ps = 1;
                end
            end else if (!en) begin
                m_run = 0; m_pos = 0;
            end else if (m_pos == PERIOD - 1) begin
                m_pos = 0; m_active = m_shadow; m_ps = 1;
            end else begin
                m_pos++;
            end
            if (load) m_shadow = eff(int'(duty_in), carry_in, neg_in, cero_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pwm_out", int'(pwm_out), int'(m_pwm));
            chk("model_period_start", int'(period_start), int'(m_ps));
            chk("model_duty_active", int'(duty_active), m_active);
            chk("model_pending", int'(pending), int'(m_shadow != m_active));
        end
    end

    task automatic do_load(input int d, input bit c, input bit n, input bit z);
        @(posedge clk); #1;
        load = 1'b1; duty_in = 4'(d); carry_in = c; neg_in = n; cero_in = z;
        @(posedge clk); #1;
        load = 1'b0; carry_in = 1'b0; neg_in = 1'b0; cero_in = 1'b0;
    endtask

    // Waits for period_start, counts pwm_out high cycles over one period
    // window, then requires the next period_start exactly PERIOD later.
    task automatic check_period(input string name, input int exp_hi);
        int n = 0;
        int hi = 0;
        @(negedge clk);
        while (!period_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!period_start) begin
            chk({name, "_start_timeout"}, 0, 1);
            return;
        end
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out) hi++;
            @(negedge clk);
        end
        chk({name, "_high_cycles"}, hi, exp_hi);
        chk({name, "_next_start"}, int'(period_start), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_duty", int'(duty_active), 0);
        chk("reset_pending", int'(pending), 0);

        // duty 4: 8 high, 24 low, period_start every 32 cycles
        do_load(4, 0, 0, 0);
        @(negedge clk);
        chk("load_pending", int'(pending), 1);
        chk("idle_duty_held", int'(duty_active), 0);
        @(posedge clk); #1 en = 1'b1;
        check_period("duty4_a", 8);
        check_period("duty4_b", 8);
        chk("duty4_active", int'(duty_active), 4);
        chk("duty4_pending", int'(pending), 0);

        // load 12 during step 6: current period stays 4, next uses 12
        repeat (12) @(posedge clk);
        #1 load = 1'b1; duty_in = 4'd12;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        chk("mid_pending", int'(pending), 1);
        chk("mid_duty_held", int'(duty_active), 4);
        check_period("mid_next12", 24);
        chk("mid_active12", int'(duty_active), 12);
        chk("mid_pending_clr", int'(pending), 0);

        // carry saturates: first window misses the previous step-15 cycle
        do_load(3, 1, 0, 0);
        check_period("carry_a", 31);
        check_period("carry_b", 32);
        chk("carry_active", int'(duty_active), 16);

        do_load(5, 0, 1, 0);
        check_period("neg_a", 1);
        check_period("neg_b", 0);
        chk("neg_active", int'(duty_active), 0);

        do_load(6, 0, 0, 0);
        check_period("plain6", 12);
        do_load(9, 0, 0, 1);
        check_period("cero", 0);
        chk("cero_active", int'(duty_active), 0);

        // load 7 early, then load 2 on the boundary tick cycle (cycle 31)
        load = 1'b0;
        @(posedge clk); #1 load = 1'b1; duty_in = 4'd7;
        @(posedge clk); #1 load = 1'b0;
        repeat (29) @(posedge clk);
        #1 load = 1'b1; duty_in = 4'd2;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        chk("coinc_active7", int'(duty_active), 7);
        chk("coinc_pending", int'(pending), 1);
        check_period("coinc_then2", 4);
        chk("coinc_active2", int'(duty_active), 2);
        chk("coinc_pending_clr", int'(pending), 0);

        // en dropped at step 2 while pwm is high
        do_load(12, 0, 0, 0);
        check_period("pre_drop12", 24);
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        chk("drop_pwm_still_high", int'(pwm_out), 1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("drop_pwm_low", int'(pwm_out), 0);
        chk("drop_active_held", int'(duty_active), 12);
        repeat (5) @(posedge clk);
        do_load(5, 0, 0, 0);
        @(negedge clk);
        chk("idle_load_pending", int'(pending), 1);
        chk("idle_load_active", int'(duty_active), 12);
        @(posedge clk); #1 en = 1'b1;
        check_period("restart5", 10);
        chk("restart_active", int'(duty_active), 5);

        // reset mid-RUN with active 9
        do_load(9, 0, 0, 0);
        check_period("pre_rst9", 18);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_duty", int'(duty_active), 0);
        chk("rst_pending", int'(pending), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("post_rst_pwm", int'(pwm_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
